dii_packet_buffer: RTL and testbench
====================================

# dii_packet_buffer

Store-and-forward packet buffer for the debug interconnect. It sits between a debug module's outgoing DII packet stream and the local input port of its ring router, using the flat 16-bit valid/ready/first/last port form of the ring wrapper. In full-packet mode it holds each packet until its last word has arrived, so a slow module cannot stall the ring partway through a packet.

## Interface
- `WIDTH`, 16, data word width (DII word)
- `BUFFER_SIZE`, 4, storage depth in words; legal range ≥ 2; need not be a power of two
- `FULLPACKET`, 1, 1 = forward only complete packets; 0 = plain FIFO (cut-through)

- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in WIDTH: upstream word
- `in_valid` in 1: upstream word valid
- `in_first` in 1: first word of packet
- `in_last` in 1: last word of packet
- `in_ready` out 1: buffer accepts word
- `out_data` out WIDTH: downstream word
- `out_valid` out 1: downstream word valid
- `out_first` out 1: first flag of presented word
- `out_last` out 1: last flag of presented word
- `out_ready` in 1: downstream accepts word

## Operation
- Storage: `BUFFER_SIZE` entries of `{first, last, data}`, circular.
  - Write pointer and read pointer are each `$clog2(BUFFER_SIZE)` bits wide.
  - Each pointer wraps from `BUFFER_SIZE-1` to 0.
- Occupancy counter `count`: `$clog2(BUFFER_SIZE+1)` bits.
  - Write only: +1. Read only: −1. Both in the same cycle: unchanged.
- Complete-packet counter `pkt_cnt`: same width as `count`.
  - +1 when a word with `last=1` is written.
  - −1 when a word with `last=1` is read.
  - Both in the same cycle: unchanged.
- Write condition: `in_valid && in_ready`. Read condition: `out_valid && out_ready`.
- `in_ready = !rst && (count != BUFFER_SIZE)`.
- `out_valid`:
  - `FULLPACKET=0`: `count != 0`.
  - `FULLPACKET=1`: `count != 0 && (pkt_cnt != 0 || count == BUFFER_SIZE)`.
- Oversize-packet fallback (`FULLPACKET=1`): if the buffer fills with no complete packet stored, words drain one at a time as space cycles. Packets are never dropped and never deadlock.
- `out_data`, `out_first` and `out_last` come from the entry at the read pointer.
  - Held stable while `out_valid && !out_ready`.
  - Don't-care when `out_valid=0`.
- Flags are passed through unchecked; no protocol repair.

## Timing
- Reset values:
  - `count`, `pkt_cnt` and both pointers = 0.
  - `out_valid=0`.
  - `in_ready=0` while `rst=1`; `in_ready=1` in the first cycle after reset release.
  - Storage contents are not reset.
- Reset mid-packet discards all stored words, including partial packets.
- Latency:
  - A word written in cycle N can be presented at the earliest in cycle N+1.
  - `FULLPACKET=0`: exactly N+1 if the buffer was empty.
  - `FULLPACKET=1`: first word presented in the cycle after the last word is written.
- Throughput: one word per cycle in each direction, sustained.
- `in_ready` depends only on registered state. With a full buffer, a read in cycle N raises `in_ready` in cycle N+1; there is no same-cycle pass-through.
- `out_valid` depends only on registered state; there is no combinational in→out path.
- Empty: a read is impossible. Full: a write is impossible. Counters never over- or under-flow.

## Structure
- The flat port form is used; no struct ports.
- The `dii_channel` typedef and the word width constant live in the shared DII package. No new package entries.
- Storage and control stay in this module; no sub-module is needed.

## Test plan
- `FULLPACKET=1`, `BUFFER_SIZE=4`, `out_ready=1`; write 0x1000(first), 0x2000, 0x3000(last) in cycles 1–3.
  - `out_valid=0` through cycle 3.
  - Words are presented in cycles 4, 5, 6; `out_first` set on 0x1000, `out_last` set on 0x3000.
- `FULLPACKET=0`; write a single-word packet 0xABCD in cycle 1 → `out_valid=1` with 0xABCD in cycle 2.
- `out_ready=0`; write four single-word packets.
  - `in_ready=0` from the cycle after the 4th write; a 5th word is held off.
  - Pulse `out_ready` for one cycle → `in_ready=1` the next cycle; the 5th word is accepted.
- `FULLPACKET=1`, `BUFFER_SIZE=4`; write a 6-word packet with `out_ready=1`.
  - `out_valid` asserts after the 4th write.
  - All 6 words arrive in order; `pkt_cnt` returns to 0.
- Same-cycle read of a `last` word and write of a `last` word → `pkt_cnt` and `count` unchanged; data order preserved.
- Assert `rst` after 2 words of a 3-word packet.
  - `in_ready=0` during reset; after reset, `out_valid=0`.
  - A following 1-word packet is delivered alone.

Source files
------------

// File: rtl/dii_packet_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dii_packet_buffer_pkg
//
// Purpose: shared DII definitions used by the debug interconnect blocks. It
// holds the DII word width and the dii_channel bundle that describes one
// word travelling between a debug module and its ring router.
//
// Contents:
//   DII_WIDTH   - width of one DII word (16 bits)
//   dii_channel - packed {valid, first, last, data} word bundle
// -----------------------------------------------------------------------------
package dii_packet_buffer_pkg;

    localparam int DII_WIDTH = 16;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [DII_WIDTH-1:0] data;
    } dii_channel;

endpackage

// File: rtl/dii_packet_buffer.sv
// -----------------------------------------------------------------------------
// dii_packet_buffer
//
// Purpose: store-and-forward packet buffer between a debug module's outgoing
// DII stream and the local input port of its ring router. With FULLPACKET=1
// a packet is only presented downstream once its last word is stored, so a
// slow producer cannot stall the ring in the middle of a packet. A packet
// larger than the buffer falls back to draining word by word once the buffer
// is full, so nothing is dropped and nothing deadlocks. With FULLPACKET=0 the
// block is a plain cut-through FIFO.
//
// Parameters:
//   WIDTH       - data word width
//   BUFFER_SIZE - storage depth in words (>= 2, any value)
//   FULLPACKET  - 1 = forward complete packets only, 0 = plain FIFO
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_data    in   upstream word
//   in_valid   in   upstream word valid
//   in_first   in   first word of packet
//   in_last    in   last word of packet
//   in_ready   out  buffer accepts a word this cycle
//   out_data   out  word at the read pointer
//   out_valid  out  downstream word valid
//   out_first  out  first flag of presented word
//   out_last   out  last flag of presented word
//   out_ready  in   downstream accepts the word
// -----------------------------------------------------------------------------
module dii_packet_buffer
    import dii_packet_buffer_pkg::*;
#(
    parameter int WIDTH       = DII_WIDTH,
    parameter int BUFFER_SIZE = 4,
    parameter int FULLPACKET  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam int EW = WIDTH + 2;

    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_SIZE - 1);

    // Entry layout: {first, last, data}
    logic [EW-1:0] r_mem [BUFFER_SIZE];

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pktCnt;

    logic          w_write;
    logic          w_read;
    logic          w_wrLast;
    logic          w_rdLast;
    logic [EW-1:0] w_head;

    // Pointers wrap explicitly because the depth need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Handshakes. Both ready and valid are built only from registered state
    // (plus reset for in_ready), so there is no combinational in->out path.
    assign in_ready = !rst && (r_count != FULL_CNT);

    // In full-packet mode a word is only offered once a complete packet is
    // stored, or when the buffer is full with an oversize packet that would
    // otherwise never complete.
    assign out_valid = (r_count != '0) &&
                       ((FULLPACKET == 0) || (r_pktCnt != '0) || (r_count == FULL_CNT));

    assign w_write  = in_valid && in_ready;
    assign w_read   = out_valid && out_ready;
    assign w_head   = r_mem[r_rdPtr];
    assign w_wrLast = w_write && in_last;
    assign w_rdLast = w_read && w_head[WIDTH];

    assign out_first = w_head[WIDTH+1];
    assign out_last  = w_head[WIDTH];
    assign out_data  = w_head[WIDTH-1:0];

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= {in_first, in_last, in_data};
        end
    end

    // Pointer and counter control. Simultaneous increment and decrement
    // cancel, which keeps both counters inside their legal range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_pktCnt <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_read) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_wrLast, w_rdLast})
                2'b10:   r_pktCnt <= r_pktCnt + CW'(1);
                2'b01:   r_pktCnt <= r_pktCnt - CW'(1);
                default: r_pktCnt <= r_pktCnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dii_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_dii_packet_buffer
//
// Directed testbench for dii_packet_buffer. Two instances share the upstream
// data/flag lines and reset: dutP in full-packet mode and dutC in cut-through
// mode, each with its own valid/ready handshake. Accepted words are queued as
// expected output and compared when each instance hands a word downstream.
// -----------------------------------------------------------------------------
module tb_dii_packet_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] inData;
    logic        inFirst;
    logic        inLast;
    logic        inValidP, inValidC;
    logic        inReadyP, inReadyC;
    logic [15:0] outDataP, outDataC;
    logic        outValidP, outValidC;
    logic        outFirstP, outFirstC;
    logic        outLastP, outLastC;
    logic        outReadyP, outReadyC;

    int checks = 0;
    int errors = 0;

    logic [17:0] sbP[$];
    logic [17:0] sbC[$];

    dii_packet_buffer #(.WIDTH(16), .BUFFER_SIZE(4), .FULLPACKET(1)) dutP (
        .clk      (clk),
        .rst      (rst),
        .in_data  (inData),
        .in_valid (inValidP),
        .in_first (inFirst),
        .in_last  (inLast),
        .in_ready (inReadyP),
        .out_data (outDataP),
        .out_valid(outValidP),
        .out_first(outFirstP),
        .out_last (outLastP),
        .out_ready(outReadyP)
    );

    dii_packet_buffer #(.WIDTH(16), .BUFFER_SIZE(4), .FULLPACKET(0)) dutC (
        .clk      (clk),
        .rst      (rst),
        .in_data  (inData),
        .in_valid (inValidC),
        .in_first (inFirst),
        .in_last  (inLast),
        .in_ready (inReadyC),
        .out_data (outDataC),
        .out_valid(outValidC),
        .out_first(outFirstC),
        .out_last (outLastC),
        .out_ready(outReadyC)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and every failure
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word into the selected instance (0 = dutP, 1 = dutC), waiting
    // a bounded number of cycles for in_ready, and queue it as expected output.
    task automatic applyStimulus(input int sel, input logic [15:0] d, input logic f, input logic l);
        int waitCyc;
        logic rdy;
        waitCyc = 0;
        inData  = d;
        inFirst = f;
        inLast  = l;
        if (sel == 0) inValidP = 1'b1; else inValidC = 1'b1;
        @(negedge clk);
        rdy = (sel == 0) ? inReadyP : inReadyC;
        while (!rdy && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
            rdy = (sel == 0) ? inReadyP : inReadyC;
        end
        checkOutput("acceptTimeout", {31'b0, rdy}, 32'd1);
        if (rdy) begin
            if (sel == 0) sbP.push_back({f, l, d});
            else          sbC.push_back({f, l, d});
        end
        @(posedge clk);
        #1;
        inValidP = 1'b0;
        inValidC = 1'b0;
    endtask

    // Downstream monitors: each accepted output word must match the oldest
    // expected entry for that instance.
    always @(negedge clk) begin
        if (!rst && outValidP && outReadyP) begin
            if (sbP.size() == 0) begin
                checkOutput("unexpectedWordP", {16'b0, outDataP}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("wordP", {14'b0, outFirstP, outLastP, outDataP}, {14'b0, sbP.pop_front()});
            end
        end
        if (!rst && outValidC && outReadyC) begin
            if (sbC.size() == 0) begin
                checkOutput("unexpectedWordC", {16'b0, outDataC}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("wordC", {14'b0, outFirstC, outLastC, outDataC}, {14'b0, sbC.pop_front()});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        inData    = '0;
        inFirst   = 1'b0;
        inLast    = 1'b0;
        inValidP  = 1'b0;
        inValidC  = 1'b0;
        outReadyP = 1'b0;
        outReadyC = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("rstInReadyP", {31'b0, inReadyP}, 32'd0);
        checkOutput("rstInReadyC", {31'b0, inReadyC}, 32'd0);
        checkOutput("rstOutValidP", {31'b0, outValidP}, 32'd0);
        checkOutput("rstOutValidC", {31'b0, outValidC}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("relInReadyP", {31'b0, inReadyP}, 32'd1);
        checkOutput("relInReadyC", {31'b0, inReadyC}, 32'd1);
        tick();

        // Full-packet mode: 3-word packet held until its last word is stored
        $display("[TB] full-packet 3-word packet");
        outReadyP = 1'b1;
        applyStimulus(0, 16'h1000, 1'b1, 1'b0);
        checkOutput("holdValid1", {31'b0, outValidP}, 32'd0);
        applyStimulus(0, 16'h2000, 1'b0, 1'b0);
        checkOutput("holdValid2", {31'b0, outValidP}, 32'd0);
        applyStimulus(0, 16'h3000, 1'b0, 1'b1);
        checkOutput("pres1Valid", {31'b0, outValidP}, 32'd1);
        checkOutput("pres1Data", {16'b0, outDataP}, 32'h1000);
        checkOutput("pres1First", {31'b0, outFirstP}, 32'd1);
        tick();
        checkOutput("pres2Data", {16'b0, outDataP}, 32'h2000);
        tick();
        checkOutput("pres3Data", {16'b0, outDataP}, 32'h3000);
        checkOutput("pres3Last", {31'b0, outLastP}, 32'd1);
        tick();
        checkOutput("pktDoneValid", {31'b0, outValidP}, 32'd0);

        // Cut-through mode: single word visible the cycle after it is written
        $display("[TB] cut-through single word");
        outReadyC = 1'b1;
        applyStimulus(1, 16'hABCD, 1'b1, 1'b1);
        checkOutput("ctValid", {31'b0, outValidC}, 32'd1);
        checkOutput("ctData", {16'b0, outDataC}, 32'hABCD);
        tick();
        outReadyC = 1'b0;

        // Cut-through backpressure: fill, hold off a fifth word, free one slot
        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 16'h0100 + 16'(i), 1'b1, 1'b1);
        end
        checkOutput("fullInReady", {31'b0, inReadyC}, 32'd0);
        inData   = 16'h0104;
        inFirst  = 1'b1;
        inLast   = 1'b1;
        inValidC = 1'b1;
        tick();
        checkOutput("heldOffInReady", {31'b0, inReadyC}, 32'd0);
        outReadyC = 1'b1;
        tick();
        outReadyC = 1'b0;
        checkOutput("slotFreeInReady", {31'b0, inReadyC}, 32'd1);
        sbC.push_back({1'b1, 1'b1, 16'h0104});
        tick();
        inValidC = 1'b0;
        checkOutput("refullInReady", {31'b0, inReadyC}, 32'd0);
        outReadyC = 1'b1;
        repeat (6) tick();
        checkOutput("ctDrained", sbC.size(), 32'd0);
        checkOutput("ctEmptyValid", {31'b0, outValidC}, 32'd0);

        // Full-packet mode: oversize 6-word packet drains once the buffer fills
        $display("[TB] oversize packet");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 16'h4000 + 16'(i), (i == 0), (i == 5));
            if (i == 2) checkOutput("ovHoldValid", {31'b0, outValidP}, 32'd0);
            if (i == 3) begin
                checkOutput("ovFullValid", {31'b0, outValidP}, 32'd1);
                checkOutput("ovFullData", {16'b0, outDataP}, 32'h4000);
            end
        end
        repeat (10) tick();
        checkOutput("ovDrained", sbP.size(), 32'd0);
        checkOutput("ovPktCnt", 32'(dutP.r_pktCnt), 32'd0);
        checkOutput("ovCount", 32'(dutP.r_count), 32'd0);

        // Same-cycle read and write of last words
        $display("[TB] simultaneous last read/write");
        applyStimulus(0, 16'h5000, 1'b1, 1'b1);
        applyStimulus(0, 16'h5001, 1'b1, 1'b1);
        checkOutput("simCount", 32'(dutP.r_count), 32'd1);
        checkOutput("simPktCnt", 32'(dutP.r_pktCnt), 32'd1);
        checkOutput("simData", {16'b0, outDataP}, 32'h5001);
        tick();
        checkOutput("simCountEnd", 32'(dutP.r_count), 32'd0);

        // Reset in the middle of a packet discards the partial packet
        $display("[TB] reset mid-packet");
        applyStimulus(0, 16'h6000, 1'b1, 1'b0);
        applyStimulus(0, 16'h6001, 1'b0, 1'b0);
        rst = 1'b1;
        sbP.delete();
        #1;
        checkOutput("midRstInReady", {31'b0, inReadyP}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("postRstValid", {31'b0, outValidP}, 32'd0);
        checkOutput("postRstInReady", {31'b0, inReadyP}, 32'd1);
        applyStimulus(0, 16'h7000, 1'b1, 1'b1);
        checkOutput("afterRstValid", {31'b0, outValidP}, 32'd1);
        checkOutput("afterRstData", {16'b0, outDataP}, 32'h7000);
        checkOutput("afterRstFlags", {30'b0, outFirstP, outLastP}, 32'd3);
        repeat (4) tick();
        checkOutput("afterRstDrained", sbP.size(), 32'd0);
        checkOutput("afterRstIdle", {31'b0, outValidP}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
